frame_packetizer: RTL and testbench

- Write-side producer for the ping-pong packet buffer.
- Captures the 8-bit image-sensor pixel bus (fv/lv/pix) in the wr_clk (pixel clock) domain.
- Splits each frame into fixed PACKAGE_SIZE-byte packets, each starting with a 4-byte header, and drives the buffer's wr_en/din.
- A small skid FIFO absorbs header-insertion cycles; the final packet of a frame is zero-padded, so every packet is exactly PACKAGE_SIZE bytes.

---
 rtl/frame_packetizer_pkg.sv | 39 +++
 rtl/frame_packetizer_skid.sv | 56 +++++
 rtl/frame_packetizer.sv | 259 +++++++++++++++++++++++++
 tb/tb_frame_packetizer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_packetizer_pkg.sv
// Shared constants, FSM state type and header helper for the frame packetizer.
package frame_packetizer_pkg;

    localparam int         HDR_BYTES = 4;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] HDR_IDX_SYNC  = 2'd0;
    localparam logic [1:0] HDR_IDX_FLAGS = 2'd1;
    localparam logic [1:0] HDR_IDX_FRAME = 2'd2;
    localparam logic [1:0] HDR_IDX_PKT   = 2'd3;

    localparam int SOF_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PAD     = 3'd3,
        ST_END     = 3'd4
    } state_e;

    function automatic logic [7:0] hdr_byte(
        input logic [1:0] idx,
        input logic       sof,
        input logic [7:0] fnum,
        input logic [7:0] pidx
    );
        logic [7:0] b;
        b = '0;
        case (idx)
            HDR_IDX_SYNC:  b = SYNC_BYTE;
            HDR_IDX_FLAGS: b[SOF_BIT] = sof;
            HDR_IDX_FRAME: b = fnum;
            default:       b = pidx;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/frame_packetizer_skid.sv
// Pixel skid FIFO: synchronous, power-of-2 depth, head word read straight from
// the storage registers so the consumer can register it on the pop cycle.
module pix_skid_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_WIDTH-1:0]    din_i,
    output logic [DATA_WIDTH-1:0]    dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = count_q;

endmodule

// File: rtl/frame_packetizer.sv
// Sensor-side packet producer: splits each frame into fixed-size headed packets.
// Build option PKT_CHECKSUM_EN makes the last packet byte the XOR of payload+pad.
//
//   state   | meaning
//   IDLE    | no frame in flight, waiting for fv rising edge
//   HDR     | emitting the 4 header bytes
//   PAYLOAD | draining skid pixels into the packet
//   PAD     | zero-filling the final packet of a frame
//   END     | frame closed, bump frame number
module frame_packetizer
    import frame_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PACKAGE_SIZE = 4864,
    parameter int SKID_DEPTH   = 16
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  fv,
    input  logic                  lv,
    input  logic [DATA_WIDTH-1:0] pix,
    input  logic                  sink_block,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] din,
    output logic [7:0]            frame_num,
    output logic                  pkt_active,
    output logic                  skid_ovf
);

`ifdef PKT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(PACKAGE_SIZE + 1);
    localparam int LVL_W = $clog2(SKID_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HDR_CNT  = CNT_W'(HDR_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKAGE_SIZE - 1);

    state_e                state_q, state_d;
    logic [1:0]            hdr_idx_q, hdr_idx_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]            pkt_idx_q, pkt_idx_d;
    logic [7:0]            frame_num_q, frame_num_d;
    logic                  sof_q, sof_d;
    logic                  pend_sof_q, pend_sof_d;
    logic [LVL_W-1:0]      old_left_q, old_left_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic                  fv_d_q;
    logic                  capture_en_q, capture_en_d;
    logic                  skid_ovf_q, skid_ovf_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  pkt_active_q, pkt_active_d;

    logic                  fv_rise;
    logic                  push;
    logic                  push_old;
    logic                  pop;
    logic                  skid_drop;
    logic                  cur_avail;
    logic                  cur_cap;
    logic                  sof_taken;
    logic                  pkt_done;
    logic                  more;
    logic [DATA_WIDTH-1:0] skid_dout;
    logic                  skid_full;
    logic                  skid_empty;
    logic [LVL_W-1:0]      skid_level;

    pix_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk_i   (wr_clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (pix),
        .dout_o  (skid_dout),
        .full_o  (skid_full),
        .empty_o (skid_empty),
        .level_o (skid_level)
    );

    assign fv_rise   = fv && !fv_d_q;
    assign push      = fv && lv && (capture_en_q || fv_rise);
    assign skid_drop = push && skid_full && !pop;
    // Once a new frame is pending, only the old_left oldest skid entries belong
    // to the packet being built; everything behind them waits for the next SOF.
    assign push_old  = push && !fv_rise && !pend_sof_q;
    assign cur_avail = pend_sof_q ? (old_left_q != '0) : !skid_empty;
    assign cur_cap   = capture_en_q && !pend_sof_q;

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        byte_cnt_d   = byte_cnt_q;
        pkt_idx_d    = pkt_idx_q;
        frame_num_d  = frame_num_q;
        sof_d        = sof_q;
        pend_sof_d   = pend_sof_q;
        old_left_d   = old_left_q;
        chk_d        = chk_q;
        skid_ovf_d   = skid_ovf_q;
        wr_en_d      = 1'b0;
        din_d        = din_q;
        capture_en_d = capture_en_q;
        pop          = 1'b0;
        sof_taken    = 1'b0;
        pkt_done     = 1'b0;
        more         = 1'b0;

        if (fv_rise)  capture_en_d = 1'b1;
        else if (!fv) capture_en_d = 1'b0;

        if (!sink_block) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fv_rise || pend_sof_q) begin
                        sof_taken  = 1'b1;
                        wr_en_d    = 1'b1;
                        din_d      = SYNC_BYTE;
                        hdr_idx_d  = HDR_IDX_FLAGS;
                        sof_d      = 1'b1;
                        pkt_idx_d  = '0;
                        pend_sof_d = 1'b0;
                        chk_d      = '0;
                        skid_ovf_d = 1'b0;
                        state_d    = ST_HDR;
                    end
                end
                ST_HDR: begin
                    wr_en_d   = 1'b1;
                    din_d     = hdr_byte(hdr_idx_q, sof_q, frame_num_q, pkt_idx_q);
                    hdr_idx_d = hdr_idx_q + 1'b1;
                    if (hdr_idx_q == HDR_IDX_SYNC && sof_q) skid_ovf_d = 1'b0;
                    if (hdr_idx_q == HDR_IDX_PKT) begin
                        byte_cnt_d = HDR_CNT;
                        state_d    = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (CHK_EN && byte_cnt_q == LAST_IDX) begin
                        wr_en_d    = 1'b1;
                        din_d      = chk_q;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        pkt_done   = 1'b1;
                        more       = cur_cap || (pend_sof_q ? (old_left_q != '0)
                                                            : (!skid_empty || push_old));
                    end else if (cur_avail) begin
                        pop        = 1'b1;
                        wr_en_d    = 1'b1;
                        din_d      = skid_dout;
                        chk_d      = chk_q ^ skid_dout;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (byte_cnt_q == LAST_IDX) begin
                            pkt_done = 1'b1;
                            more     = cur_cap || (pend_sof_q ? (old_left_q > LVL_W'(1))
                                                  : ((skid_level > LVL_W'(1)) || push_old));
                        end
                    end else if (!cur_cap) begin
                        state_d = (byte_cnt_q == HDR_CNT) ? ST_END : ST_PAD;
                    end
                end
                ST_PAD: begin
                    wr_en_d    = 1'b1;
                    din_d      = '0;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_IDX) begin
                        if (CHK_EN) din_d = chk_q;
                        state_d = ST_END;
                    end
                end
                ST_END: begin
                    frame_num_d = frame_num_q + 1'b1;
                    if (pend_sof_q || fv_rise) begin
                        sof_taken  = 1'b1;
                        hdr_idx_d  = HDR_IDX_SYNC;
                        sof_d      = 1'b1;
                        pkt_idx_d  = '0;
                        pend_sof_d = 1'b0;
                        chk_d      = '0;
                        state_d    = ST_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (pkt_done) begin
            if (more) begin
                hdr_idx_d = HDR_IDX_SYNC;
                sof_d     = 1'b0;
                pkt_idx_d = pkt_idx_q + 1'b1;
                chk_d     = '0;
                state_d   = ST_HDR;
            end else begin
                state_d = ST_END;
            end
        end

        if (pend_sof_q && pop) old_left_d = old_left_q - 1'b1;
        if (fv_rise && !sof_taken && !pend_sof_q) begin
            pend_sof_d = 1'b1;
            old_left_d = skid_level - LVL_W'(pop);
        end

        if (skid_drop) skid_ovf_d = 1'b1;

        pkt_active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hdr_idx_q    <= '0;
            byte_cnt_q   <= '0;
            pkt_idx_q    <= '0;
            frame_num_q  <= '0;
            sof_q        <= 1'b0;
            pend_sof_q   <= 1'b0;
            old_left_q   <= '0;
            chk_q        <= '0;
            fv_d_q       <= 1'b1;
            capture_en_q <= 1'b0;
            skid_ovf_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            pkt_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            pkt_idx_q    <= pkt_idx_d;
            frame_num_q  <= frame_num_d;
            sof_q        <= sof_d;
            pend_sof_q   <= pend_sof_d;
            old_left_q   <= old_left_d;
            chk_q        <= chk_d;
            fv_d_q       <= fv;
            capture_en_q <= capture_en_d;
            skid_ovf_q   <= skid_ovf_d;
            wr_en_q      <= wr_en_d;
            din_q        <= din_d;
            pkt_active_q <= pkt_active_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign din        = din_q;
    assign frame_num  = frame_num_q;
    assign pkt_active = pkt_active_q;
    assign skid_ovf   = skid_ovf_q;

endmodule

// File: tb/tb_frame_packetizer.sv
// Bench for frame_packetizer: random pixel frames against a packet-level model.
module tb_frame_packetizer;

    localparam int PS = 4864;
`ifdef PKT_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic       wr_clk = 1'b0;
    logic       rst_n;
    logic       fv;
    logic       lv;
    logic [7:0] pix;
    logic       sink_block;
    logic       wr_en;
    logic [7:0] din;
    logic [7:0] frame_num;
    logic       pkt_active;
    logic       skid_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] px_q[$];

    frame_packetizer dut (
        .wr_clk     (wr_clk),
        .rst_n      (rst_n),
        .fv         (fv),
        .lv         (lv),
        .pix        (pix),
        .sink_block (sink_block),
        .wr_en      (wr_en),
        .din        (din),
        .frame_num  (frame_num),
        .pkt_active (pkt_active),
        .skid_ovf   (skid_ovf)
    );

    always #5 wr_clk = ~wr_clk;

    always @(negedge wr_clk) begin
        if (wr_en === 1'b1) got.push_back(din);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected bytes of one frame: packets of header + pixels, zero pad, optional XOR.
    task automatic build_frame(input logic [7:0] fnum);
        int cap;
        int npk;
        int idx;
        logic [7:0] x;
        logic [7:0] b;
        cap = PS - 4 - CHK;
        npk = (px_q.size() + cap - 1) / cap;
        idx = 0;
        for (int k = 0; k < npk; k++) begin
            x = 8'h00;
            exp_q.push_back(8'hA5);
            exp_q.push_back((k == 0) ? 8'h80 : 8'h00);
            exp_q.push_back(fnum);
            exp_q.push_back(8'(k));
            for (int j = 0; j < cap; j++) begin
                b = (idx < px_q.size()) ? px_q[idx] : 8'h00;
                idx++;
                x = x ^ b;
                exp_q.push_back(b);
            end
            if (CHK != 0) exp_q.push_back(x);
        end
        px_q.delete();
    endtask

    task automatic cmp_stream(input string tag);
        int bad0;
        bad0 = n_bad;
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (n_bad != bad0) break;
            chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic send_pixels(input int n, input bit record);
        for (int i = 0; i < n; i++) begin
            @(negedge wr_clk);
            lv  = 1'b1;
            pix = 8'($urandom);
            if (record) px_q.push_back(pix);
        end
        @(negedge wr_clk);
        lv = 1'b0;
    endtask

    task automatic send_frame(input int lines, input int len, input bit chk_sof);
        @(negedge wr_clk);
        fv = 1'b1;
        @(negedge wr_clk);
        if (chk_sof) chk("sof_latency", {23'd0, wr_en, din}, 32'h1A5);
        repeat (2) @(negedge wr_clk);
        for (int l = 0; l < lines; l++) begin
            send_pixels(len, 1'b1);
            repeat (5) @(negedge wr_clk);
        end
        fv = 1'b0;
        @(negedge wr_clk);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (pkt_active === 1'b1 && n < 20000) begin
            @(negedge wr_clk);
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, n >= 20000}, 32'd0);
        repeat (2) @(negedge wr_clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        fv = 1'b0;
        lv = 1'b0;
        pix = 8'h00;
        sink_block = 1'b0;
        repeat (3) @(negedge wr_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge wr_clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_din", {24'd0, din}, 32'd0);
        chk("rst_frame_num", {24'd0, frame_num}, 32'd0);
        chk("rst_pkt_active", {31'd0, pkt_active}, 32'd0);
        chk("rst_skid_ovf", {31'd0, skid_ovf}, 32'd0);

        // 2 x 100 px: one packet, then frame_num advances
        send_frame(2, 100, 1'b1);
        wait_done("f0");
        chk("f0_frame_num", {24'd0, frame_num}, 32'd1);
        chk("f0_wr_en_pulses", got.size(), PS);
        build_frame(8'd0);
        cmp_stream("f0");

        // 10000 px: three packets
        send_frame(10, 1000, 1'b1);
        wait_done("f1");
        chk("f1_frame_num", {24'd0, frame_num}, 32'd2);
        chk("f1_total_bytes", got.size(), 3 * PS);
        build_frame(8'd1);
        cmp_stream("f1");

        // continuous 200 px line, no stall
        send_frame(1, 200, 1'b1);
        wait_done("f2");
        chk("f2_no_ovf", {31'd0, skid_ovf}, 32'd0);
        build_frame(8'd2);
        cmp_stream("f2");

        // 200 px with 30 stalled cycles from an empty skid: 14 pixels lost
        @(negedge wr_clk);
        fv = 1'b1;
        repeat (10) @(negedge wr_clk);
        for (int i = 0; i < 200; i++) begin
            sink_block = (i < 30);
            lv  = 1'b1;
            pix = 8'($urandom);
            if (i < 16 || i >= 30) px_q.push_back(pix);
            @(negedge wr_clk);
        end
        lv = 1'b0;
        sink_block = 1'b0;
        repeat (5) @(negedge wr_clk);
        fv = 1'b0;
        @(negedge wr_clk);
        wait_done("f3");
        chk("f3_ovf_sticky", {31'd0, skid_ovf}, 32'd1);
        build_frame(8'd3);
        cmp_stream("f3");

        // next frame rises during PAD of the previous one
        send_frame(1, 50, 1'b1);
        build_frame(8'd4);
        repeat (20) @(negedge wr_clk);
        chk("f4_in_pad_active", {31'd0, pkt_active}, 32'd1);
        chk("f4_ovf_cleared_by_sof", {31'd0, skid_ovf}, 32'd0);
        fv = 1'b1;
        repeat (3) @(negedge wr_clk);
        send_pixels(8, 1'b1);
        n = 0;
        while (frame_num !== 8'd5 && n < 10000) begin
            @(negedge wr_clk);
            n++;
        end
        chk("f4_end_timeout", {31'd0, n >= 10000}, 32'd0);
        repeat (30) @(negedge wr_clk);
        send_pixels(40, 1'b1);
        repeat (5) @(negedge wr_clk);
        fv = 1'b0;
        @(negedge wr_clk);
        wait_done("f5");
        build_frame(8'd5);
        cmp_stream("f4f5");

        // reset mid-payload, released while fv is still high
        @(negedge wr_clk);
        fv = 1'b1;
        repeat (3) @(negedge wr_clk);
        send_pixels(60, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge wr_clk);
        rst_n = 1'b1;
        got.delete();
        send_pixels(40, 1'b0);
        repeat (10) @(negedge wr_clk);
        chk("rst_mid_no_output", got.size(), 0);
        chk("rst_mid_frame_num", {24'd0, frame_num}, 32'd0);
        chk("rst_mid_pkt_active", {31'd0, pkt_active}, 32'd0);
        fv = 1'b0;
        repeat (3) @(negedge wr_clk);
        send_frame(1, 30, 1'b1);
        wait_done("f6");
        build_frame(8'd0);
        cmp_stream("f6");

        // pixels 01,02,03: last packet byte is 00 with or without checksum
        @(negedge wr_clk);
        fv = 1'b1;
        repeat (3) @(negedge wr_clk);
        for (int i = 1; i <= 3; i++) begin
            lv  = 1'b1;
            pix = 8'(i);
            px_q.push_back(pix);
            @(negedge wr_clk);
        end
        lv = 1'b0;
        repeat (3) @(negedge wr_clk);
        fv = 1'b0;
        @(negedge wr_clk);
        wait_done("f7");
        chk("f7_last_byte", {24'd0, (got.size() == PS) ? got[PS-1] : 8'hFF}, 32'h00);
        build_frame(8'd1);
        cmp_stream("f7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
